// File: rtl/switcher_scheduler_if.sv
// Bundle of request, switch, capture and handshake signals between the
// 3-source output switch scheduler and its surroundings.
interface switcher_scheduler_if;
    logic        ReqSlow;
    logic        ReqPC;
    logic        ReqPD;
    logic [15:0] DataIn;
    logic [1:0]  Switch;
    logic        AckSlow;
    logic        AckPC;
    logic        AckPD;
    logic [15:0] DataOut;
    logic [1:0]  SrcTag;
    logic        OutValid;
    logic        OutReady;
    logic        Busy;
    logic [7:0]  DropCount;

    modport slave (
        input  ReqSlow, ReqPC, ReqPD, DataIn, OutReady,
        output Switch, AckSlow, AckPC, AckPD, DataOut, SrcTag, OutValid, Busy, DropCount
    );

    modport master (
        output ReqSlow, ReqPC, ReqPD, DataIn, OutReady,
        input  Switch, AckSlow, AckPC, AckPD, DataOut, SrcTag, OutValid, Busy, DropCount
    );
endinterface

// File: rtl/switcher_scheduler.sv
// Round-robin scheduler for the slow-ADC / PC / PD output switch: grants a
// pending source, lets the switch settle, captures the word, hands it off.
module switcher_scheduler #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    switcher_scheduler_if.slave  sw
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETTLE = 2'b01;
    localparam logic [1:0] ST_HOLD   = 2'b10;

    localparam logic [1:0] SW_SLOW = 2'b00;
    localparam logic [1:0] SW_PC   = 2'b01;
    localparam logic [1:0] SW_PD   = 2'b11;
    localparam logic [1:0] SW_PARK = 2'b10;

    // Source indices: 0 slow, 1 PC, 2 PD
    localparam logic [1:0] SRC_SLOW = 2'd0;
    localparam logic [1:0] SRC_PC   = 2'd1;
    localparam logic [1:0] SRC_PD   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic [2:0]       pend;
    logic [1:0]       last_gnt;
    logic [1:0]       gnt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sw_q;
    logic [2:0]       ack;
    logic [15:0]      data_q;
    logic [1:0]       tag_q;
    logic             vld_q;
    logic [7:0]       drop_q;

    logic [2:0] req;
    logic [2:0] clr;
    logic [2:0] drops;
    logic [1:0] pick;
    logic       capture;

    // First pending source strictly after the last grant, wrapping Slow->PC->PD.
    function automatic logic [1:0] rr_pick(input logic [2:0] p, input logic [1:0] l);
        logic [1:0] o0, o1, o2;
        case (l)
            SRC_SLOW: begin o0 = SRC_PC;   o1 = SRC_PD;   o2 = SRC_SLOW; end
            SRC_PC:   begin o0 = SRC_PD;   o1 = SRC_SLOW; o2 = SRC_PC;   end
            default:  begin o0 = SRC_SLOW; o1 = SRC_PC;   o2 = SRC_PD;   end
        endcase
        if (p[o0])      return o0;
        else if (p[o1]) return o1;
        else            return o2;
    endfunction

    function automatic logic [1:0] src_code(input logic [1:0] s);
        case (s)
            SRC_SLOW: return SW_SLOW;
            SRC_PC:   return SW_PC;
            default:  return SW_PD;
        endcase
    endfunction

    function automatic logic [2:0] src_onehot(input logic [1:0] s);
        case (s)
            SRC_SLOW: return 3'b001;
            SRC_PC:   return 3'b010;
            default:  return 3'b100;
        endcase
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] d);
        logic [8:0] s;
        s = {1'b0, a} + {8'd0, d[0]} + {8'd0, d[1]} + {8'd0, d[2]};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign req     = {sw.ReqPD, sw.ReqPC, sw.ReqSlow};
    assign capture = (state == ST_SETTLE) && (cnt == '0);
    assign clr     = capture ? src_onehot(gnt) : 3'b000;
    // A request landing on its own capture edge re-arms the flag rather than dropping.
    assign drops   = req & pend & ~clr;
    assign pick    = rr_pick(pend, last_gnt);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            pend     <= 3'b000;
            last_gnt <= SRC_PD;
            gnt      <= SRC_PD;
            cnt      <= '0;
            sw_q     <= SW_PARK;
            ack      <= 3'b000;
            data_q   <= 16'h0000;
            tag_q    <= 2'b00;
            vld_q    <= 1'b0;
            drop_q   <= 8'h00;
        end else begin
            pend   <= (pend & ~clr) | req;
            drop_q <= sat_add(drop_q, drops);
            ack    <= 3'b000;
            case (state)
                ST_IDLE: begin
                    if (|pend) begin
                        gnt   <= pick;
                        sw_q  <= src_code(pick);
                        cnt   <= CNT_LOAD;
                        state <= ST_SETTLE;
                    end else begin
                        sw_q <= SW_PARK;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        data_q   <= sw.DataIn;
                        tag_q    <= sw_q;
                        vld_q    <= 1'b1;
                        ack      <= src_onehot(gnt);
                        last_gnt <= gnt;
                        state    <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (vld_q && sw.OutReady) begin
                        vld_q <= 1'b0;
                        sw_q  <= SW_PARK;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    sw_q  <= SW_PARK;
                end
            endcase
        end
    end

    assign sw.Switch    = sw_q;
    assign sw.AckSlow   = ack[0];
    assign sw.AckPC     = ack[1];
    assign sw.AckPD     = ack[2];
    assign sw.DataOut   = data_q;
    assign sw.SrcTag    = tag_q;
    assign sw.OutValid  = vld_q;
    assign sw.Busy      = (state != ST_IDLE);
    assign sw.DropCount = drop_q;

endmodule

// File: tb/tb_switcher_scheduler.sv
// Scoreboard bench for switcher_scheduler: inputs driven and outputs sampled
// on the falling edge; DataIn is modelled as the switch mux over three words.
module tb_switcher_scheduler;

    typedef struct packed {
        logic [1:0]  tag;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switcher_scheduler_if sw();

    switcher_scheduler #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .Clk   (clk),
        .Reset (rst),
        .sw    (sw)
    );

    logic [15:0] slow_word = 16'h1111;
    logic [15:0] pc_word   = 16'h2222;
    logic [15:0] pd_word   = 16'h3333;

    always_comb begin
        case (sw.Switch)
            2'b00:   sw.DataIn = slow_word;
            2'b01:   sw.DataIn = pc_word;
            2'b11:   sw.DataIn = pd_word;
            default: sw.DataIn = 16'h0000;
        endcase
    end

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acks_slow = 0, acks_pc = 0, acks_pd = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sw.AckSlow === 1'b1) acks_slow <= acks_slow + 1;
        if (sw.AckPC === 1'b1)   acks_pc   <= acks_pc + 1;
        if (sw.AckPD === 1'b1)   acks_pd   <= acks_pd + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sw.ReqSlow = 1'b0; sw.ReqPC = 1'b0; sw.ReqPD = 1'b0;
        sw.OutReady = 1'b0;
        tick(); tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_valid(input int budget, output int cycles, output bit to);
        cycles = 0;
        while (sw.OutValid !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        to = (sw.OutValid !== 1'b1);
    endtask

    task automatic test_reset();
        bit bad = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (sw.Switch !== 2'b10 || sw.OutValid !== 1'b0 || sw.Busy !== 1'b0 ||
                sw.DropCount !== 8'd0 || sw.DataOut !== 16'h0 || sw.SrcTag !== 2'b00)
                bad = 1;
            tick();
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL reset_idle: sw=%b vld=%b busy=%b drop=%0d dout=%h tag=%b, required sw=10 vld=0 busy=0 drop=0 dout=0 tag=00",
                     sw.Switch, sw.OutValid, sw.Busy, sw.DropCount, sw.DataOut, sw.SrcTag);
        end
    endtask

    task automatic test_single_pc();
        int c; bit to; int a0; exp_t e;
        do_reset();
        sw.OutReady = 1'b1;
        pc_word = 16'hA5A5;
        a0 = acks_pc;
        sw.ReqPC = 1'b1;
        sb.push_back({2'b01, 16'hA5A5});
        tick();
        sw.ReqPC = 1'b0;
        wait_valid(20, c, to);
        n_vec++;
        if (to || c != 3) begin
            n_err++; $display("FAIL pc_latency: got %0d clocks (timeout=%0d), required 3", c, to);
        end
        n_vec++;
        e = sb.pop_front();
        if ({sw.SrcTag, sw.DataOut} !== {e.tag, e.data}) begin
            n_err++; $display("FAIL pc_word: got tag=%b data=%h, required tag=%b data=%h", sw.SrcTag, sw.DataOut, e.tag, e.data);
        end
        n_vec++;
        if (sw.AckPC !== 1'b1 || sw.Switch !== 2'b01) begin
            n_err++; $display("FAIL pc_capture: got ack=%b sw=%b, required ack=1 sw=01", sw.AckPC, sw.Switch);
        end
        tick();
        n_vec++;
        if (sw.OutValid !== 1'b0 || sw.Switch !== 2'b10 || sw.DataOut !== 16'hA5A5) begin
            n_err++; $display("FAIL pc_release: got vld=%b sw=%b dout=%h, required vld=0 sw=10 dout=a5a5", sw.OutValid, sw.Switch, sw.DataOut);
        end
        tick(); tick();
        n_vec++;
        if (acks_pc - a0 != 1 || sw.Busy !== 1'b0) begin
            n_err++; $display("FAIL pc_ack_count: got %0d pulses busy=%b, required 1 pulse busy=0", acks_pc - a0, sw.Busy);
        end
    endtask

    task automatic test_round_robin();
        int c; bit to; int t_prev; exp_t e; int as, ap, ad;
        do_reset();
        sw.OutReady = 1'b1;
        slow_word = 16'h0F0F; pc_word = 16'h00FF; pd_word = 16'hF00D;
        as = acks_slow; ap = acks_pc; ad = acks_pd;
        sw.ReqSlow = 1'b1; sw.ReqPC = 1'b1; sw.ReqPD = 1'b1;
        sb.push_back({2'b00, 16'h0F0F});
        sb.push_back({2'b01, 16'h00FF});
        sb.push_back({2'b11, 16'hF00D});
        tick();
        sw.ReqSlow = 1'b0; sw.ReqPC = 1'b0; sw.ReqPD = 1'b0;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(20, c, to);
            n_vec++;
            if (to) begin
                n_err++; $display("FAIL rr_timeout: word %0d never became valid", k);
            end else begin
                e = sb.pop_front();
                if ({sw.SrcTag, sw.DataOut} !== {e.tag, e.data}) begin
                    n_err++; $display("FAIL rr_word%0d: got tag=%b data=%h, required tag=%b data=%h", k, sw.SrcTag, sw.DataOut, e.tag, e.data);
                end
                if (k > 0) begin
                    n_vec++;
                    if (cyc - t_prev != 4) begin
                        n_err++; $display("FAIL rr_spacing%0d: got %0d clocks, required 4", k, cyc - t_prev);
                    end
                end
                t_prev = cyc;
            end
            tick();
        end
        tick(); tick();
        n_vec++;
        if (acks_slow - as != 1 || acks_pc - ap != 1 || acks_pd - ad != 1 || sw.DropCount !== 8'd0) begin
            n_err++; $display("FAIL rr_acks: got slow=%0d pc=%0d pd=%0d drop=%0d, required 1 1 1 drop=0",
                              acks_slow - as, acks_pc - ap, acks_pd - ad, sw.DropCount);
        end
    endtask

    task automatic test_backpressure();
        int c; bit to; exp_t e; bit bad = 0;
        do_reset();
        sw.OutReady = 1'b0;
        pd_word = 16'hBEEF;
        sw.ReqPD = 1'b1;
        sb.push_back({2'b11, 16'hBEEF});
        tick();
        sw.ReqPD = 1'b0;
        wait_valid(20, c, to);
        n_vec++;
        e = sb.pop_front();
        if (to || {sw.SrcTag, sw.DataOut} !== {e.tag, e.data}) begin
            n_err++; $display("FAIL bp_first: got tag=%b data=%h timeout=%0d, required tag=%b data=%h", sw.SrcTag, sw.DataOut, to, e.tag, e.data);
        end
        for (int i = 0; i < 10; i++) begin
            if (sw.OutValid !== 1'b1 || sw.DataOut !== 16'hBEEF || sw.Switch !== 2'b11) bad = 1;
            sw.ReqPD = (i == 2 || i == 5);
            if (i == 2) begin
                pd_word = 16'hCAFE;
                sb.push_back({2'b11, 16'hCAFE});
            end
            tick();
        end
        sw.ReqPD = 1'b0;
        n_vec++;
        if (bad) begin
            n_err++; $display("FAIL bp_hold: got vld=%b dout=%h sw=%b, required held vld=1 dout=beef sw=11", sw.OutValid, sw.DataOut, sw.Switch);
        end
        n_vec++;
        if (sw.DropCount !== 8'd1) begin
            n_err++; $display("FAIL bp_drop: got %0d, required 1", sw.DropCount);
        end
        sw.OutReady = 1'b1;
        tick();
        n_vec++;
        if (sw.OutValid !== 1'b0 || sw.Switch !== 2'b10) begin
            n_err++; $display("FAIL bp_release: got vld=%b sw=%b, required vld=0 sw=10", sw.OutValid, sw.Switch);
        end
        wait_valid(20, c, to);
        n_vec++;
        if (to || sb.size() != 1) begin
            n_err++; $display("FAIL bp_second: timeout=%0d queued=%0d, required a second word", to, sb.size());
        end else begin
            e = sb.pop_front();
            if ({sw.SrcTag, sw.DataOut} !== {e.tag, e.data}) begin
                n_err++; $display("FAIL bp_second: got tag=%b data=%h, required tag=%b data=%h", sw.SrcTag, sw.DataOut, e.tag, e.data);
            end
        end
        tick();
        wait_valid(8, c, to);
        n_vec++;
        if (!to) begin
            n_err++; $display("FAIL bp_dropped_word: got an extra word tag=%b data=%h, required none", sw.SrcTag, sw.DataOut);
        end
    endtask

    task automatic test_drop_saturate();
        int c; bit to; exp_t e;
        do_reset();
        sw.OutReady = 1'b0;
        pc_word = 16'h1234; slow_word = 16'h5678;
        sw.ReqPC = 1'b1;
        sb.push_back({2'b01, 16'h1234});
        tick();
        sw.ReqPC = 1'b0;
        wait_valid(20, c, to);
        sw.ReqSlow = 1'b1;
        sb.push_back({2'b00, 16'h5678});
        for (int i = 1; i <= 301; i++) begin
            tick();
            if (i == 200) begin
                n_vec++;
                if (sw.DropCount !== 8'd199) begin
                    n_err++; $display("FAIL drop_count: got %0d, required 199", sw.DropCount);
                end
            end
        end
        sw.ReqSlow = 1'b0;
        n_vec++;
        if (sw.DropCount !== 8'd255) begin
            n_err++; $display("FAIL drop_saturate: got %0d, required 255", sw.DropCount);
        end
        n_vec++;
        e = sb.pop_front();
        if (to || {sw.SrcTag, sw.DataOut} !== {e.tag, e.data}) begin
            n_err++; $display("FAIL sat_pc_word: got tag=%b data=%h timeout=%0d, required tag=%b data=%h", sw.SrcTag, sw.DataOut, to, e.tag, e.data);
        end
        sw.OutReady = 1'b1;
        tick();
        wait_valid(20, c, to);
        n_vec++;
        e = sb.pop_front();
        if (to || {sw.SrcTag, sw.DataOut} !== {e.tag, e.data}) begin
            n_err++; $display("FAIL sat_slow_word: got tag=%b data=%h timeout=%0d, required tag=%b data=%h", sw.SrcTag, sw.DataOut, to, e.tag, e.data);
        end
    endtask

    task automatic test_reset_mid_settle();
        int c; bit to; exp_t e; int ap; bit bad = 0;
        do_reset();
        sw.OutReady = 1'b1;
        pc_word = 16'h7777; pd_word = 16'h9999;
        sw.ReqPC = 1'b1;
        tick();
        sw.ReqPC = 1'b0;
        tick();
        n_vec++;
        if (sw.Switch !== 2'b01 || sw.Busy !== 1'b1) begin
            n_err++; $display("FAIL rst_settle_pre: got sw=%b busy=%b, required sw=01 busy=1", sw.Switch, sw.Busy);
        end
        ap = acks_pc;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (sw.Switch !== 2'b10 || sw.Busy !== 1'b0 || sw.OutValid !== 1'b0) begin
            n_err++; $display("FAIL rst_settle_post: got sw=%b busy=%b vld=%b, required sw=10 busy=0 vld=0", sw.Switch, sw.Busy, sw.OutValid);
        end
        for (int i = 0; i < 6; i++) begin
            if (sw.OutValid !== 1'b0 || sw.Busy !== 1'b0) bad = 1;
            tick();
        end
        n_vec++;
        if (bad || acks_pc != ap) begin
            n_err++; $display("FAIL rst_discard: got %0d AckPC pulses, stray activity=%0d, required 0 and 0", acks_pc - ap, bad);
        end
        sw.ReqPD = 1'b1;
        sb.push_back({2'b11, 16'h9999});
        tick();
        sw.ReqPD = 1'b0;
        wait_valid(20, c, to);
        n_vec++;
        e = sb.pop_front();
        if (to || c != 3 || {sw.SrcTag, sw.DataOut} !== {e.tag, e.data}) begin
            n_err++; $display("FAIL rst_then_pd: got tag=%b data=%h after %0d clocks, required tag=%b data=%h after 3",
                              sw.SrcTag, sw.DataOut, c, e.tag, e.data);
        end
    endtask

    initial begin
        sw.ReqSlow = 1'b0; sw.ReqPC = 1'b0; sw.ReqPD = 1'b0; sw.OutReady = 1'b0;
        test_reset();
        test_single_pc();
        test_round_robin();
        test_backpressure();
        test_drop_saturate();
        test_reset_mid_settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
